// File: rtl/net_router_output_ctrl_param.sv
// Output-port controller: round-robin arbitration with wormhole lock
// and an idle bubble whenever the owning security domain changes.
module net_router_output_ctrl_param #(
  parameter int p_num_reqs  = 3,
  parameter int p_bubble    = 1,
  parameter int c_sel_nbits = $clog2(p_num_reqs)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_num_reqs-1:0]  reqs,
  input  logic [p_num_reqs-1:0]  reqs_domain,
  input  logic [p_num_reqs-1:0]  reqs_tail,
  output logic [p_num_reqs-1:0]  grants,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic                   out_domain,
  output logic [c_sel_nbits-1:0] xbar_sel
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCKED,
    S_SWITCH
  } state_t;

  localparam logic [c_sel_nbits-1:0] c_last =
    c_sel_nbits'(p_num_reqs - 1);

  state_t                 r_state;
  logic [c_sel_nbits-1:0] r_ptr;
  logic [c_sel_nbits-1:0] r_owner;
  logic [c_sel_nbits-1:0] r_last_sel;
  logic                   r_out_domain;
  logic [3:0]             r_bub_cnt;

  logic                   w_found;
  logic [c_sel_nbits-1:0] w_win;
  logic                   w_gnt;
  logic [c_sel_nbits-1:0] w_gidx;
  logic                   w_dom_eq;

  function automatic logic [c_sel_nbits-1:0] f_next(
    input logic [c_sel_nbits-1:0] x
  );
    return (x == c_last) ? '0 : x + 1'b1;
  endfunction

  // Round-robin search from r_ptr upward; nearest offset wins.
  always_comb begin
    logic [c_sel_nbits:0] v_sum;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = p_num_reqs - 1; k >= 0; k--) begin
      v_sum = {1'b0, r_ptr} + (c_sel_nbits + 1)'(k);
      if (v_sum >= (c_sel_nbits + 1)'(p_num_reqs))
        v_sum = v_sum - (c_sel_nbits + 1)'(p_num_reqs);
      if (reqs[v_sum[c_sel_nbits-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_sum[c_sel_nbits-1:0];
      end
    end
  end

  assign w_dom_eq = (reqs_domain[w_win] == r_out_domain);

  // Combinational grant: head in IDLE, only the owner in LOCKED.
  always_comb begin
    w_gnt  = 1'b0;
    w_gidx = r_owner;
    unique case (r_state)
      S_IDLE: begin
        if (w_found && w_dom_eq && out_rdy) begin
          w_gnt  = 1'b1;
          w_gidx = w_win;
        end
      end
      S_LOCKED: begin
        if (reqs[r_owner] && out_rdy) w_gnt = 1'b1;
      end
      default: w_gnt = 1'b0;
    endcase
  end

  assign grants     = w_gnt ? (p_num_reqs'(1) << w_gidx) : '0;
  assign out_val    = w_gnt;
  assign xbar_sel   = w_gnt ? w_gidx : r_last_sel;
  assign out_domain = r_out_domain;

  // Arbitration state, lock ownership and domain-switch bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_last_sel   <= '0;
      r_out_domain <= 1'b0;
      r_bub_cnt    <= '0;
    end else begin
      if (w_gnt) r_last_sel <= w_gidx;
      unique case (r_state)
        S_IDLE: begin
          if (w_found && !w_dom_eq) begin
            r_out_domain <= reqs_domain[w_win];
            if (p_bubble != 0) begin
              r_state   <= S_SWITCH;
              r_bub_cnt <= 4'(p_bubble);
            end
          end else if (w_gnt) begin
            if (reqs_tail[w_win]) begin
              r_ptr <= f_next(w_win);
            end else begin
              r_owner <= w_win;
              r_state <= S_LOCKED;
            end
          end
        end
        S_SWITCH: begin
          r_bub_cnt <= r_bub_cnt - 1'b1;
          if (r_bub_cnt <= 4'd1) r_state <= S_IDLE;
        end
        S_LOCKED: begin
          if (w_gnt && reqs_tail[r_owner]) begin
            r_state <= S_IDLE;
            r_ptr   <= f_next(r_owner);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/net_router_output_ctrl_param.md
# net_router_output_ctrl_param

Parametrised output-port controller for the secure mesh router. It arbitrates among `p_num_reqs` input ports with a round-robin policy and holds each grant for a whole multi-flit packet (wormhole lock). It tracks the security domain currently driving the output and inserts a configurable idle bubble whenever ownership passes to a different domain. One instance sits per router output port, driving the crossbar select and the output valid.

## Interface
Parameters:
- `p_num_reqs`, default 3: number of input ports competing for this output; must be ≥ 2.
- `p_bubble`, default 1: idle cycles inserted on a domain switch; range 0–15.
- `c_sel_nbits`, derived as `$clog2(p_num_reqs)`: width of `xbar_sel`.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset reset, synchronous, active-high.
- `reqs` input `p_num_reqs`: bit i is high when input i presents a flit routed to this output.
- `reqs_domain` input `p_num_reqs`: bit i is the security domain of input i's flit.
- `reqs_tail` input `p_num_reqs`: bit i is high when input i's presented flit is the packet tail. A single-flit packet has head and tail in the same flit.
- `grants` output `p_num_reqs`: one-hot or zero; bit i high means input i's flit transfers this cycle.
- `out_val` output 1: output valid, equal to the OR of `grants`.
- `out_rdy` input 1: downstream ready.
- `out_domain` output 1: registered domain currently owning the output.
- `xbar_sel` output `c_sel_nbits`: crossbar select index.

## Operation
- State machine states: IDLE, LOCKED, SWITCH. Registers: `state`, `ptr` (priority pointer), `owner`, `out_domain`, `bub_cnt`, `last_sel`.
- Winner selection: round-robin over raw `reqs`, searching from `ptr` upward with wrap-around. Input `ptr` has the highest priority.
- IDLE, no request: grants are 0 and no state changes.
- IDLE, winner's domain equals `out_domain`:
  - If `out_rdy` is high, grant the winner combinationally.
  - If that flit is a tail, the state stays IDLE and `ptr` becomes (winner+1) mod `p_num_reqs`.
  - If it is not a tail, `owner` is set to the winner and the state goes to LOCKED; `ptr` is unchanged.
  - If `out_rdy` is low, grants are 0 and no state changes.
- IDLE, winner's domain differs from `out_domain`:
  - Grants are 0, regardless of `out_rdy`.
  - `out_domain` is loaded with the winner's domain at the clock edge.
  - If `p_bubble` is 0, the state stays IDLE; otherwise it goes to SWITCH with `bub_cnt` = `p_bubble`.
- SWITCH: grants are 0 and `bub_cnt` decrements each cycle. The state returns to IDLE on the cycle `bub_cnt` = 1, then re-arbitrates.
- LOCKED:
  - Only `owner` may be granted, when `reqs[owner]` and `out_rdy` are both high.
  - A granted tail flit sends the state to IDLE and sets `ptr` to (owner+1) mod `p_num_reqs`.
  - If `reqs[owner]` drops, the block stays LOCKED with no grant. No other input may be granted.
- `xbar_sel`:
  - Equals the granted index whenever `out_val` is high.
  - Otherwise it holds `last_sel`, which is updated on every grant.
- `out_val` is the OR of `grants`. A transfer occurs on any cycle `out_val` is high, because grants are already gated by `out_rdy`.
- `reqs_domain` of a locked owner is ignored until the tail transfers. Domain is checked only at packet head, in IDLE.

## Timing
- Reset values: state IDLE, `ptr` 0, `owner` 0, `out_domain` 0, `bub_cnt` 0, `last_sel` 0, `xbar_sel` 0, `grants` 0, `out_val` 0.
- Same-domain head: grant in the same cycle as the request (0-cycle combinational latency).
- Domain switch detected in cycle t: first grant possible in cycle t+1+`p_bubble`.
- Back-to-back packets from different inputs of the same domain: no idle cycle between the tail of one and the head of the next.
- Reset asserted mid-packet or in SWITCH: all registers return to reset values at that edge, and grants are 0 in the following cycle unless the IDLE conditions hold.
- A request arriving while another input is LOCKED waits until the cycle after the owner's tail transfers.
- Pointer wrap: an owner or winner at `p_num_reqs`−1 sets `ptr` to 0.

## Test plan
- Reset, then inputs 0 and 2 each request a single-flit domain-0 packet with `out_rdy` high, for N=3 → cycle 0 grants 001 with `xbar_sel` 0; cycle 1 grants 100 with `xbar_sel` 2; then `ptr` = 0.
- Input 1 sends a 3-flit packet while input 0 requests throughout, all domain 0 → grants 010 for three cycles, then 001; `xbar_sel` holds 1 during any `out_rdy`-low stall.
- Input 0 requests with domain 1 and `out_domain` = 0, `p_bubble` = 2 → no grant for 3 cycles, `out_domain` = 1 from cycle 1, grant 001 at cycle 3.
- `out_rdy` low for 4 cycles mid-packet → `out_val` 0, `grants` 0, state stays LOCKED, and the remaining flits transfer once `out_rdy` rises.
- Reset pulsed while LOCKED on input 2 → next cycle `ptr` 0 and `out_domain` 0, and a request from input 0 is granted immediately.
- `p_num_reqs` = 5, all inputs requesting single-flit packets continuously → grant order 0,1,2,3,4,0, with `ptr` wrapping to 0.
